// File: rtl/sc_decoder_pkg.sv
// Shared types and width helpers for the stochastic output decoder.
package sc_decoder_pkg;
  typedef enum logic {ST_ACCUM = 1'b0, ST_SCAN = 1'b1} state_e;

  function automatic int cnt_width(input int window);
    return $clog2(window + 1);
  endfunction

  // A single node still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sc_bit_counter.sv
// Per-node ones counter: synchronous reset/clear, counts i_bit when enabled.
module sc_bit_counter #(
  parameter int W = 9
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)    r_cnt <= '0;
    else if (i_en && i_bit) r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/sc_output_decoder.sv
// Stochastic-to-binary classifier: windowed ones count per node, then a
// sequential argmax scan, result presented with a valid/ack handshake.
module sc_output_decoder
  import sc_decoder_pkg::*;
#(
  parameter  int N_OUT  = 8,
  parameter  int WINDOW = 256,
  localparam int CNT_W  = cnt_width(WINDOW),
  localparam int IDX_W  = idx_width(N_OUT)
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic [N_OUT-1:0] a_in,
  input  logic             EN,
  input  logic             result_ack,
  output logic             result_valid,
  output logic [IDX_W-1:0] class_idx,
  output logic [CNT_W-1:0] max_count,
  output logic             overrun,
  output logic             busy
);
  state_e                        r_state, w_next;
  logic [CNT_W-1:0]              r_win;
  logic [IDX_W-1:0]              r_k;
  logic [CNT_W-1:0]              r_best;
  logic [IDX_W-1:0]              r_best_idx;
  logic [N_OUT-1:0][CNT_W-1:0]   w_cnt;
  logic                          w_accum, w_win_last, w_scan_last, w_take;
  logic [CNT_W-1:0]              w_cur, w_new_best;
  logic [IDX_W-1:0]              w_new_idx;

  assign w_accum     = (r_state == ST_ACCUM) && EN;
  assign w_win_last  = w_accum && (r_win == CNT_W'(WINDOW - 1));
  assign w_scan_last = (r_state == ST_SCAN) && (r_k == IDX_W'(N_OUT - 1));
  assign busy        = (r_state == ST_SCAN);

  // Strict greater-than keeps the lowest index on ties; k=0 always loads.
  assign w_cur      = w_cnt[r_k];
  assign w_take     = (r_k == '0) || (w_cur > r_best);
  assign w_new_best = w_take ? w_cur : r_best;
  assign w_new_idx  = w_take ? r_k   : r_best_idx;

  for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
    sc_bit_counter #(.W(CNT_W)) u_cnt (
      .i_clk (CLK),
      .i_rst (INIT),
      .i_clr (w_scan_last),
      .i_en  (w_accum),
      .i_bit (a_in[g]),
      .o_cnt (w_cnt[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (INIT) r_state <= ST_ACCUM;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ACCUM: if (w_win_last)  w_next = ST_SCAN;
      ST_SCAN:  if (w_scan_last) w_next = ST_ACCUM;
      default:                   w_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      r_win        <= '0;
      r_k          <= '0;
      r_best       <= '0;
      r_best_idx   <= '0;
      class_idx    <= '0;
      max_count    <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (w_accum) r_win <= w_win_last ? '0 : r_win + CNT_W'(1);
      if (r_state == ST_SCAN) begin
        r_k        <= w_scan_last ? '0 : r_k + IDX_W'(1);
        r_best     <= w_new_best;
        r_best_idx <= w_new_idx;
      end
      // A fresh result beats a same-cycle ack; only an unacked overwrite is an overrun.
      if (w_scan_last) begin
        class_idx    <= w_new_idx;
        max_count    <= w_new_best;
        result_valid <= 1'b1;
        overrun      <= overrun | (result_valid & ~result_ack);
      end else if (result_ack) begin
        result_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sc_output_decoder.sv
// Randomized and directed bench for sc_output_decoder against a window/argmax model.
module tb_sc_output_decoder;
  localparam int N  = 8;
  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);
  localparam int IW = $clog2(N);

  logic          CLK = 1'b0;
  logic          INIT = 1'b1, EN = 1'b0, result_ack = 1'b0;
  logic [N-1:0]  a_in = '0;
  logic          result_valid, overrun, busy;
  logic [IW-1:0] class_idx;
  logic [CW-1:0] max_count;

  sc_output_decoder #(.N_OUT(N), .WINDOW(W)) dut (
    .CLK(CLK), .INIT(INIT), .a_in(a_in), .EN(EN), .result_ack(result_ack),
    .result_valid(result_valid), .class_idx(class_idx), .max_count(max_count),
    .overrun(overrun), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  int m_cnt[N];
  int m_win, m_dead;
  int m_valid, m_idx, m_max, m_ovr;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_win = 0; m_dead = 0;
    m_valid = 0; m_idx = 0; m_max = 0; m_ovr = 0;
  endtask

  // One clock edge of the model: window accumulation, then N dead cycles,
  // after which the argmax of the window becomes the result.
  task automatic model_edge(input logic i, input logic e, input logic [N-1:0] a, input logic k);
    bit load = 0;
    int best, bidx;
    if (i) begin
      model_clear();
      return;
    end
    if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) begin
        load = 1;
        best = m_cnt[0]; bidx = 0;
        for (int n = 1; n < N; n++) if (m_cnt[n] > best) begin best = m_cnt[n]; bidx = n; end
        if (m_valid && !k) m_ovr = 1;
        m_valid = 1; m_idx = bidx; m_max = best;
        foreach (m_cnt[n]) m_cnt[n] = 0;
      end
    end else if (e) begin
      for (int n = 0; n < N; n++) m_cnt[n] += a[n];
      m_win++;
      if (m_win == W) begin m_win = 0; m_dead = N; end
    end
    if (!load && k) m_valid = 0;
  endtask

  task automatic step(input logic i, input logic e, input logic [N-1:0] a, input logic k);
    INIT = i; EN = e; a_in = a; result_ack = k;
    @(posedge CLK);
    model_edge(i, e, a, k);
    #1;
    chk("busy",  busy,         m_dead > 0);
    chk("valid", result_valid, m_valid);
    chk("idx",   class_idx,    m_idx);
    chk("max",   max_count,    m_max);
    chk("ovr",   overrun,      m_ovr);
  endtask

  task automatic scan_cycles(input logic k_last);
    for (int c = 0; c < N; c++)
      step(0, 1'($urandom), N'($urandom), (c == N-1) ? k_last : 1'b0);
  endtask

  task automatic expect_zero(input string nm);
    chk({nm, "_busy"},  busy, 0);
    chk({nm, "_valid"}, result_valid, 0);
    chk({nm, "_idx"},   class_idx, 0);
    chk({nm, "_max"},   max_count, 0);
    chk({nm, "_ovr"},   overrun, 0);
  endtask

  initial begin
    logic [N-1:0] a;
    model_clear();
    step(1, 0, '0, 0);
    expect_zero("reset");

    // Constant node 2
    for (int c = 0; c < W; c++) step(0, 1, 8'h04, 0);
    chk("t1_busy", busy, 1);
    scan_cycles(0);
    chk("t1_valid", result_valid, 1);
    chk("t1_idx", class_idx, 2);
    chk("t1_max", max_count, 16);
    step(0, 0, '0, 1);

    // Tie between nodes 1 and 5
    for (int c = 0; c < W; c++) begin
      a = '0; a[1] = (c < 10); a[5] = (c >= 6);
      step(0, 1, a, 0);
    end
    scan_cycles(0);
    chk("t2_idx", class_idx, 1);
    chk("t2_max", max_count, 10);
    step(0, 0, '0, 1);

    // EN toggling, all ones
    for (int c = 0; c < 2*W - 1; c++) step(0, (c % 2) == 0, 8'hFF, 0);
    scan_cycles(0);
    chk("t3_valid", result_valid, 1);
    chk("t3_idx", class_idx, 0);
    chk("t3_max", max_count, 16);

    // Overrun across two unacked windows
    step(1, 0, '0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < W; c++) step(0, 1, N'($urandom), 0);
      scan_cycles(0);
    end
    chk("t4_valid", result_valid, 1);
    chk("t4_ovr", overrun, 1);

    // Ack on the load edge does not overrun
    step(1, 0, '0, 0);
    for (int c = 0; c < W; c++) step(0, 1, N'($urandom), 0);
    scan_cycles(0);
    for (int c = 0; c < W; c++) step(0, 1, N'($urandom), 0);
    scan_cycles(1);
    chk("t5_valid", result_valid, 1);
    chk("t5_ovr", overrun, 0);
    step(0, 0, '0, 1);
    chk("t5_ack", result_valid, 0);

    // INIT mid-window and mid-scan
    step(1, 0, '0, 0);
    for (int c = 0; c < 7; c++) step(0, 1, 8'hFF, 0);
    step(1, 1, 8'hFF, 0);
    expect_zero("t6_win");
    for (int c = 0; c < W; c++) step(0, 1, N'($urandom), 0);
    for (int c = 0; c < 3; c++) step(0, 1, 8'hFF, 0);
    step(1, 1, 8'hFF, 0);
    expect_zero("t6_scan");

    // All-zero window after the discarded one
    for (int c = 0; c < W; c++) step(0, 1, '0, 0);
    chk("t7_pre", result_valid, 0);
    scan_cycles(0);
    chk("t7_valid", result_valid, 1);
    chk("t7_idx", class_idx, 0);
    chk("t7_max", max_count, 0);

    // Random traffic
    for (int c = 0; c < 1500; c++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, N'($urandom),
           $urandom_range(0, 9) < 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
